data_mem_ctrl: RTL and testbench

- Memory-side responder for the core's data-memory interface: accepts load/store requests from the memory stage and returns read words on ReadDataM.
- Holds a word-organised data RAM with byte-lane writes.
- Loads take a configurable, fixed number of wait cycles, during which MemStall holds the pipeline.
- Sits beside data_path and connects to ALUResultM, WriteDataM, WidthSrcMOUT, MemWriteM and ReadDataM.

---
 rtl/data_mem_ctrl_if.sv | 25 ++
 rtl/data_mem_ctrl.sv | 109 ++++++++++
 tb/tb_data_mem_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Data-memory bus between the memory stage and the data RAM responder.
// The memory stage is the master; the RAM controller is the slave.
interface data_mem_ctrl_if;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [1:0]  WidthSrcM;
    logic        MemWriteM;
    logic        MemReadM;
    logic        StallM;
    logic [31:0] ReadDataM;
    logic        MemStall;
    logic        MisalignM;

    modport master (
        output ALUResultM, WriteDataM, WidthSrcM,
        output MemWriteM, MemReadM, StallM,
        input  ReadDataM, MemStall, MisalignM
    );

    modport slave (
        input  ALUResultM, WriteDataM, WidthSrcM,
        input  MemWriteM, MemReadM, StallM,
        output ReadDataM, MemStall, MisalignM
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Word-organised data RAM with byte-lane stores and fixed-latency loads.
// Loads stall the pipeline via MemStall until the word is presented in RESP.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 2
) (
    input logic           clk,
    input logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state;
    logic [3:0]    cnt;
    logic [31:0]   mem [DEPTH_WORDS];
    logic [31:0]   rbuf;
    logic [31:0]   rdata;
    logic          mis_q;
    logic [AW-1:0] idx;
    logic [1:0]    a;
    logic          mis;
    logic          st_go;
    logic          ld_go;
    logic [3:0]    be;
    logic [31:0]   wd;
    logic          unused_addr;

    assign a           = bus.ALUResultM[1:0];
    assign idx         = bus.ALUResultM[AW+1:2];
    assign unused_addr = ^bus.ALUResultM[31:AW+2];

    always_comb begin
        mis = 1'b0;
        be  = 4'b0000;
        wd  = bus.WriteDataM;
        unique case (bus.WidthSrcM)
            2'b00: begin
                mis = |a;
                be  = 4'b1111;
            end
            2'b01: begin
                mis = a[0];
                be  = a[1] ? 4'b1100 : 4'b0011;
                wd  = {2{bus.WriteDataM[15:0]}};
            end
            2'b10: begin
                be = 4'b0001 << a;
                wd = {4{bus.WriteDataM[7:0]}};
            end
            default: mis = 1'b1;
        endcase
    end

    // A store in IDLE always wins over a simultaneous load request.
    assign st_go = (state == IDLE) && bus.MemWriteM;
    assign ld_go = (state == IDLE) && bus.MemReadM && !bus.MemWriteM;

    assign bus.MemStall  = ld_go || (state == WAIT);
    assign bus.ReadDataM = rdata;
    assign bus.MisalignM = mis_q;

    always_ff @(posedge clk) begin
        if (st_go && !mis) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
            end
        end
        if (ld_go) rbuf <= mem[idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            rdata <= 32'd0;
            mis_q <= 1'b0;
        end else begin
            mis_q <= (st_go || ld_go) && mis;
            unique case (state)
                IDLE: begin
                    if (ld_go) begin
                        cnt <= 4'(READ_LATENCY - 1);
                        if (READ_LATENCY == 1) begin
                            state <= RESP;
                            rdata <= mem[idx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd1) begin
                        state <= RESP;
                        cnt   <= 4'd0;
                        rdata <= rbuf;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!bus.StallM) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: latency-2/1024-word and latency-1/16-word instances.
// Expected load data is queued when a load is issued and checked at response.
module tb_data_mem_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [31:0] sbq[$];

    always #5 clk = ~clk;

    data_mem_ctrl_if a_if();
    data_mem_ctrl_if b_if();

    data_mem_ctrl #(.DEPTH_WORDS(1024), .READ_LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave)
    );

    data_mem_ctrl #(.DEPTH_WORDS(16), .READ_LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sw_a(input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] w, input logic exp_mis,
                        input string nm);
        tick();
        a_if.ALUResultM = addr;
        a_if.WriteDataM = data;
        a_if.WidthSrcM  = w;
        a_if.MemWriteM  = 1'b1;
        a_if.MemReadM   = 1'b0;
        @(negedge clk);
        total++;
        if (a_if.MemStall !== 1'b0) begin
            bad++;
            $display("FAIL %s stall: got %b want 0", nm, a_if.MemStall);
        end
        tick();
        a_if.MemWriteM = 1'b0;
        @(negedge clk);
        total++;
        if (a_if.MisalignM !== exp_mis) begin
            bad++;
            $display("FAIL %s mis: got %b want %b", nm, a_if.MisalignM, exp_mis);
        end
        tick();
        @(negedge clk);
        total++;
        if (a_if.MisalignM !== 1'b0) begin
            bad++;
            $display("FAIL %s mis_end: got %b want 0", nm, a_if.MisalignM);
        end
    endtask

    task automatic wait_resp_a(input int exp_lat, input int exp_mis,
                               input string nm);
        int n = 0;
        int m = 0;
        logic [31:0] exp;
        @(negedge clk);
        while (a_if.MemStall === 1'b1 && n < 20) begin
            n++;
            if (a_if.MisalignM === 1'b1) m++;
            @(negedge clk);
        end
        if (a_if.MisalignM === 1'b1) m++;
        total++;
        if (n != exp_lat) begin
            bad++;
            $display("FAIL %s lat: got %0d want %0d", nm, n, exp_lat);
        end
        total++;
        if (m != exp_mis) begin
            bad++;
            $display("FAIL %s mis: got %0d want %0d", nm, m, exp_mis);
        end
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL %s sb: got empty want entry", nm);
        end else begin
            exp = sbq.pop_front();
            if (a_if.ReadDataM !== exp) begin
                bad++;
                $display("FAIL %s data: got %h want %h", nm, a_if.ReadDataM, exp);
            end
        end
    endtask

    task automatic lw_a(input logic [31:0] addr, input logic [31:0] exp,
                        input int exp_mis, input string nm);
        tick();
        a_if.ALUResultM = addr;
        a_if.WidthSrcM  = 2'b00;
        a_if.MemWriteM  = 1'b0;
        a_if.MemReadM   = 1'b1;
        sbq.push_back(exp);
        wait_resp_a(2, exp_mis, nm);
        tick();
        a_if.MemReadM = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (a_if.ReadDataM !== 32'd0) begin
            bad++;
            $display("FAIL rst_rd: got %h want 0", a_if.ReadDataM);
        end
        total++;
        if (a_if.MemStall !== 1'b0) begin
            bad++;
            $display("FAIL rst_stall: got %b want 0", a_if.MemStall);
        end
        total++;
        if (a_if.MisalignM !== 1'b0) begin
            bad++;
            $display("FAIL rst_mis: got %b want 0", a_if.MisalignM);
        end
        total++;
        if (b_if.ReadDataM !== 32'd0 || b_if.MemStall !== 1'b0) begin
            bad++;
            $display("FAIL rst_b: got %h/%b want 0/0", b_if.ReadDataM, b_if.MemStall);
        end
    endtask

    task automatic test_word();
        logic [31:0] d[4];
        sw_a(32'h10, 32'hDEADBEEF, 2'b00, 1'b0, "sw10");
        lw_a(32'h10, 32'hDEADBEEF, 0, "lw10");
        for (int i = 0; i < 4; i++) begin
            d[i] = $urandom;
            sw_a(32'h100 + 32'(4*i), d[i], 2'b00, 1'b0, "sw_sweep");
        end
        for (int i = 0; i < 4; i++) begin
            lw_a(32'h100 + 32'(4*i), d[i], 0, "lw_sweep");
        end
    endtask

    task automatic test_lanes();
        sw_a(32'h20, 32'h11223344, 2'b00, 1'b0, "sw20");
        sw_a(32'h21, 32'h000000AA, 2'b10, 1'b0, "sb21");
        sw_a(32'h22, 32'h0000BEEF, 2'b01, 1'b0, "sh22");
        lw_a(32'h20, 32'hBEEFAA44, 0, "lw_lanes");
    endtask

    task automatic test_misalign();
        sw_a(32'h20, 32'h11223344, 2'b00, 1'b0, "sw20b");
        sw_a(32'h23, 32'h00005555, 2'b01, 1'b1, "sh23");
        sw_a(32'h20, 32'h00000000, 2'b11, 1'b1, "sres");
        sw_a(32'h22, 32'hFFFFFFFF, 2'b00, 1'b1, "sw22");
        lw_a(32'h22, 32'h11223344, 1, "lw22");
        sw_a(32'h23, 32'h00000077, 2'b10, 1'b0, "sb23");
        lw_a(32'h20, 32'h77223344, 0, "lw_sb23");
    endtask

    task automatic test_rw_conflict();
        tick();
        a_if.ALUResultM = 32'h30;
        a_if.WriteDataM = 32'hCAFEF00D;
        a_if.WidthSrcM  = 2'b00;
        a_if.MemWriteM  = 1'b1;
        a_if.MemReadM   = 1'b1;
        @(negedge clk);
        total++;
        if (a_if.MemStall !== 1'b0) begin
            bad++;
            $display("FAIL rw_stall: got %b want 0", a_if.MemStall);
        end
        tick();
        a_if.MemWriteM = 1'b0;
        a_if.MemReadM  = 1'b0;
        lw_a(32'h30, 32'hCAFEF00D, 0, "lw_rw");
    endtask

    task automatic test_back_to_back();
        sw_a(32'h24, 32'h0BADC0DE, 2'b00, 1'b0, "sw24");
        tick();
        a_if.ALUResultM = 32'h20;
        a_if.MemReadM   = 1'b1;
        sbq.push_back(32'h77223344);
        wait_resp_a(2, 0, "lw_hold");
        a_if.StallM = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) begin
                tick();
                a_if.StallM = 1'b0;
            end else begin
                tick();
            end
            @(negedge clk);
            total++;
            if (a_if.ReadDataM !== 32'h77223344 || a_if.MemStall !== 1'b0) begin
                bad++;
                $display("FAIL hold: got %h/%b want 77223344/0",
                         a_if.ReadDataM, a_if.MemStall);
            end
        end
        tick();
        a_if.ALUResultM = 32'h24;
        sbq.push_back(32'h0BADC0DE);
        wait_resp_a(2, 0, "lw_b2b");
        tick();
        a_if.MemReadM = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        tick();
        a_if.ALUResultM = 32'h10;
        a_if.MemReadM   = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        total++;
        if (a_if.MemStall !== 1'b1) begin
            bad++;
            $display("FAIL wait_stall: got %b want 1", a_if.MemStall);
        end
        reset = 1'b1;
        a_if.MemReadM = 1'b0;
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (a_if.MemStall !== 1'b0 || a_if.ReadDataM !== 32'd0) begin
            bad++;
            $display("FAIL rst_wait: got %b/%h want 0/0",
                     a_if.MemStall, a_if.ReadDataM);
        end
        lw_a(32'h10, 32'hDEADBEEF, 0, "lw_after_rst");
    endtask

    task automatic test_alias();
        logic [31:0] st_addr[2];
        logic [31:0] ld_addr[2];
        logic [31:0] dat[2];
        logic [31:0] exp;
        int n;
        st_addr = '{32'h04, 32'h48};
        ld_addr = '{32'h44, 32'h08};
        dat     = '{32'h13579BDF, 32'h2468ACE0};
        for (int i = 0; i < 2; i++) begin
            tick();
            b_if.ALUResultM = st_addr[i];
            b_if.WriteDataM = dat[i];
            b_if.WidthSrcM  = 2'b00;
            b_if.MemWriteM  = 1'b1;
            tick();
            b_if.MemWriteM = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            b_if.ALUResultM = ld_addr[i];
            b_if.MemReadM   = 1'b1;
            sbq.push_back(dat[i]);
            n = 0;
            @(negedge clk);
            while (b_if.MemStall === 1'b1 && n < 20) begin
                n++;
                @(negedge clk);
            end
            total++;
            if (n != 1) begin
                bad++;
                $display("FAIL alias_lat: got %0d want 1", n);
            end
            total++;
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL alias_sb: got empty want entry");
            end else begin
                exp = sbq.pop_front();
                if (b_if.ReadDataM !== exp) begin
                    bad++;
                    $display("FAIL alias_data: got %h want %h", b_if.ReadDataM, exp);
                end
            end
            tick();
            b_if.MemReadM = 1'b0;
        end
    endtask

    initial begin
        a_if.ALUResultM = 32'd0;
        a_if.WriteDataM = 32'd0;
        a_if.WidthSrcM  = 2'b00;
        a_if.MemWriteM  = 1'b0;
        a_if.MemReadM   = 1'b0;
        a_if.StallM     = 1'b0;
        b_if.ALUResultM = 32'd0;
        b_if.WriteDataM = 32'd0;
        b_if.WidthSrcM  = 2'b00;
        b_if.MemWriteM  = 1'b0;
        b_if.MemReadM   = 1'b0;
        b_if.StallM     = 1'b0;
        test_reset();
        test_word();
        test_lanes();
        test_misalign();
        test_rw_conflict();
        test_back_to_back();
        test_reset_mid_wait();
        test_alias();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
